// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared state encoding and register bank geometry
package reg_arb_pkg;
  typedef enum logic {ST_ARB = 1'b0, ST_LOCKED = 1'b1} arb_state_t;
  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 4;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first request at or after ptr wins
module rr_pick #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx,
  output logic          any
);
  // scan from the farthest offset down so the nearest request to ptr is the last write
  always_comb begin
    int j;
    j = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = PW'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin access arbiter for the single-port register bank with atomic locks
module reg_bank_arbiter
  import reg_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int MAX_LOCK = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ-1:0]        lock,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic                      bank_readEn,
  output logic                      bank_writeEn,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_wdata,
  input  logic [DATA_W-1:0]         bank_rdata
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_LOCK + 1);

  arb_state_t    state, state_nx;
  logic [PW-1:0] ptr, ptr_nx, owner, owner_nx, pick_idx, sel_idx;
  logic [CW-1:0] lock_cnt, cnt_nx;
  logic [NUM_REQ-1:0] pick_gnt;
  logic          pick_any, sel_any;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + PW'(1);
  endfunction

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req(req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx),
    .any(pick_any)
  );

  // next-state, grant and lock bookkeeping; lock_cnt counts grants in the current locked run
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    owner_nx = owner;
    cnt_nx   = lock_cnt;
    gnt      = '0;
    sel_idx  = pick_idx;
    sel_any  = 1'b0;
    if (state == ST_LOCKED) begin
      sel_idx = owner;
      if (req[owner]) begin
        gnt[owner] = 1'b1;
        sel_any    = 1'b1;
        if (lock[owner] && (int'(lock_cnt) + 1 < MAX_LOCK)) begin
          cnt_nx = lock_cnt + CW'(1);
        end else begin
          state_nx = ST_ARB;
          cnt_nx   = '0;
          ptr_nx   = next_ptr(owner);
        end
      end else begin
        state_nx = ST_ARB;
        cnt_nx   = '0;
        ptr_nx   = next_ptr(owner);
      end
    end else if (pick_any) begin
      gnt     = pick_gnt;
      sel_any = 1'b1;
      ptr_nx  = next_ptr(pick_idx);
      if (lock[pick_idx] && MAX_LOCK > 1) begin
        state_nx = ST_LOCKED;
        owner_nx = pick_idx;
        cnt_nx   = CW'(1);
      end
    end
  end

  // bank drive: granted requester's fields, all zero when idle
  always_comb begin
    bank_writeEn = sel_any & we[sel_idx];
    bank_readEn  = sel_any & ~we[sel_idx];
    bank_addr    = sel_any ? addr[int'(sel_idx)*ADDR_W +: ADDR_W] : '0;
    bank_wdata   = sel_any ? wdata[int'(sel_idx)*DATA_W +: DATA_W] : '0;
  end

  assign rdata = bank_rdata;

  // arbiter state and one-cycle-delayed read valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_ARB;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
      rvalid   <= '0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      owner    <= owner_nx;
      lock_cnt <= cnt_nx;
      rvalid   <= gnt & ~we;
    end
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed vector table plus lock/reset sequences against a bank model
module tb_reg_bank_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req, we, lock, gnt, rvalid;
  logic [11:0] addr, wdata;
  logic [3:0]  rdata, bank_addr, bank_wdata, bank_rdata;
  logic        bank_readEn, bank_writeEn;
  logic [3:0]  mem [16];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0]  req, we, lock;
    logic [11:0] addr, wdata;
    logic [2:0]  gnt, rvalid;
    logic [3:0]  rdata;
    logic        ck, bre, bwe;
    logic [3:0]  baddr, bwd;
  } vec_t;
  vec_t v [18];

  reg_bank_arbiter #(.NUM_REQ(3), .DATA_W(4), .ADDR_W(4), .MAX_LOCK(8)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .lock(lock),
    .addr(addr),
    .wdata(wdata),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .bank_readEn(bank_readEn),
    .bank_writeEn(bank_writeEn),
    .bank_addr(bank_addr),
    .bank_wdata(bank_wdata),
    .bank_rdata(bank_rdata)
  );

  always #5 clk = ~clk;

  // single-port bank with registered read data
  always @(posedge clk) begin
    if (bank_writeEn) mem[bank_addr] <= bank_wdata;
    if (bank_readEn) bank_rdata <= mem[bank_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l);
    @(negedge clk);
    req = r;
    we = w;
    lock = l;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bank_rdata = '0;
    v[0]  = '{3'b111, 3'b111, 3'b000, 12'h321, 12'h987, 3'b001, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h7};
    v[1]  = '{3'b110, 3'b111, 3'b000, 12'h321, 12'h987, 3'b010, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h8};
    v[2]  = '{3'b100, 3'b111, 3'b000, 12'h321, 12'h987, 3'b100, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 4'h3, 4'h9};
    v[3]  = '{3'b111, 3'b000, 3'b000, 12'h321, 12'h000, 3'b001, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 4'h1, 4'h0};
    v[4]  = '{3'b111, 3'b000, 3'b000, 12'h321, 12'h000, 3'b010, 3'b001, 4'h7, 1'b1, 1'b1, 1'b0, 4'h2, 4'h0};
    v[5]  = '{3'b111, 3'b000, 3'b000, 12'h321, 12'h000, 3'b100, 3'b010, 4'h8, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0};
    v[6]  = '{3'b111, 3'b000, 3'b000, 12'h321, 12'h000, 3'b001, 3'b100, 4'h9, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0};
    v[7]  = '{3'b000, 3'b000, 3'b000, 12'h321, 12'h000, 3'b000, 3'b001, 4'h7, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
    v[8]  = '{3'b001, 3'b001, 3'b000, 12'h005, 12'h00A, 3'b001, 3'b000, 4'h0, 1'b0, 1'b0, 1'b1, 4'h5, 4'hA};
    v[9]  = '{3'b010, 3'b000, 3'b000, 12'h050, 12'h000, 3'b010, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h0};
    v[10] = '{3'b000, 3'b000, 3'b000, 12'h050, 12'h000, 3'b000, 3'b010, 4'hA, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};
    v[11] = '{3'b100, 3'b000, 3'b000, 12'h300, 12'h000, 3'b100, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0};
    v[12] = '{3'b111, 3'b000, 3'b001, 12'h321, 12'h000, 3'b001, 3'b100, 4'h9, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0};
    v[13] = '{3'b111, 3'b000, 3'b001, 12'h321, 12'h000, 3'b001, 3'b001, 4'h7, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0};
    v[14] = '{3'b111, 3'b000, 3'b000, 12'h321, 12'h000, 3'b001, 3'b001, 4'h7, 1'b1, 1'b1, 1'b0, 4'h1, 4'h0};
    v[15] = '{3'b110, 3'b000, 3'b000, 12'h321, 12'h000, 3'b010, 3'b001, 4'h7, 1'b1, 1'b1, 1'b0, 4'h2, 4'h0};
    v[16] = '{3'b100, 3'b000, 3'b000, 12'h321, 12'h000, 3'b100, 3'b010, 4'h8, 1'b1, 1'b1, 1'b0, 4'h3, 4'h0};
    v[17] = '{3'b000, 3'b000, 3'b000, 12'h321, 12'h000, 3'b000, 3'b100, 4'h9, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0};

    rst = 1'b0;
    req = 3'b111;
    we = 3'b000;
    lock = 3'b000;
    addr = 12'h321;
    wdata = 12'h000;
    @(negedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'(3'b001));
    chk("reset_rvalid", 32'(rvalid), 32'(3'b000));
    req = 3'b000;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req = v[i].req;
      we = v[i].we;
      lock = v[i].lock;
      addr = v[i].addr;
      wdata = v[i].wdata;
      #1;
      chk($sformatf("v%0d_gnt", i), 32'(gnt), 32'(v[i].gnt));
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(v[i].rvalid));
      chk($sformatf("v%0d_readEn", i), 32'(bank_readEn), 32'(v[i].bre));
      chk($sformatf("v%0d_writeEn", i), 32'(bank_writeEn), 32'(v[i].bwe));
      chk($sformatf("v%0d_baddr", i), 32'(bank_addr), 32'(v[i].baddr));
      chk($sformatf("v%0d_bwdata", i), 32'(bank_wdata), 32'(v[i].bwd));
      if (v[i].ck) chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(v[i].rdata));
    end

    addr = 12'h321;
    wdata = 12'h000;
    for (int k = 0; k < 9; k++) begin
      drive(3'b011, 3'b000, 3'b001);
      chk($sformatf("timeout_gnt%0d", k), 32'(gnt), (k < 8) ? 32'(3'b001) : 32'(3'b010));
    end
    drive(3'b000, 3'b000, 3'b000);
    chk("idle_gnt", 32'(gnt), 32'(3'b000));

    drive(3'b100, 3'b000, 3'b100);
    chk("abandon_lockgnt", 32'(gnt), 32'(3'b100));
    drive(3'b011, 3'b000, 3'b000);
    chk("abandon_wait", 32'(gnt), 32'(3'b000));
    drive(3'b011, 3'b000, 3'b000);
    chk("abandon_rearb", 32'(gnt), 32'(3'b001));

    drive(3'b010, 3'b000, 3'b000);
    chk("midread_gnt", 32'(gnt), 32'(3'b010));
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 3'b000;
    #1;
    chk("midread_rvalid", 32'(rvalid), 32'(3'b000));
    @(negedge clk);
    rst = 1'b1;
    drive(3'b111, 3'b000, 3'b000);
    chk("midread_ptr", 32'(gnt), 32'(3'b001));

    drive(3'b100, 3'b000, 3'b100);
    chk("lockrst_gnt", 32'(gnt), 32'(3'b100));
    @(posedge clk);
    #2;
    rst = 1'b0;
    req = 3'b000;
    #1;
    @(negedge clk);
    rst = 1'b1;
    drive(3'b011, 3'b000, 3'b000);
    chk("lockrst_release", 32'(gnt), 32'(3'b001));
    drive(3'b000, 3'b000, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
